// File: rtl/hog_feature_reader.sv
// hog_feature_reader
//   Reads the four HOG result BRAM banks (bank-major: bank0 addr 0..FEAT_LEN-1,
//   then banks 1..3) after each rising edge of feature_done, and streams the
//   words out on a valid/ready interface through a small first-word-fall-through
//   FIFO. Reads are only issued when the FIFO is guaranteed to have room for
//   them, so any amount of backpressure is absorbed without dropping data.
// Ports
//   aclk, rst             clock, asynchronous active-high reset
//   feature_done          launch request (0->1 edge)
//   abort                 synchronous cancel, flushes everything
//   res_enb/res_addrb     BRAM read port (one-hot bank enable, shared address)
//   res_doutb_0..3        BRAM read data, RD_LAT cycles after enable
//   m_tvalid/m_tready     output handshake
//   m_tdata/tuser/tlast   zero-extended word, bank index, final-word flag
//   busy/done/overrun     status: not idle, completion pulse, sticky re-launch
module hog_feature_reader #(
  parameter int RAM_AW     = 17,
  parameter int QN         = 10,
  parameter int FEAT_LEN   = 31,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              feature_done,
  input  logic              abort,
  output logic [3:0]        res_enb,
  output logic [RAM_AW-1:0] res_addrb,
  input  logic [QN-1:0]     res_doutb_0,
  input  logic [QN-1:0]     res_doutb_1,
  input  logic [QN-1:0]     res_doutb_2,
  input  logic [QN-1:0]     res_doutb_3,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [15:0]       m_tdata,
  output logic [1:0]        m_tuser,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [RAM_AW-1:0] ADDR_LAST = RAM_AW'(FEAT_LEN - 1);
  localparam logic [PW-1:0]     PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]     DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [1:0] bank;
    logic       last;
  } tag_t;

  typedef struct packed {
    logic [QN-1:0] word;
    logic [1:0]    bank;
    logic          last;
  } beat_t;

  state_t              state, state_nxt;
  logic                fd_q, launch, start;
  logic [RAM_AW-1:0]   addr;
  logic [1:0]          bank;
  logic                issue, last_rd;
  logic [RD_LAT:1]     vld_pipe;
  tag_t                tag_pipe [RD_LAT:1];
  logic [CW-1:0]       inflight, inflight_nxt;
  logic [3:0][QN-1:0]  doutb;
  beat_t               mem [FIFO_DEPTH];
  beat_t               head, tail_beat;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // launch edge detect; abort suppresses a coincident launch
  assign launch = feature_done & ~fd_q;
  assign start  = launch && (state == IDLE) && !abort;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) fd_q <= 1'b0;
    else     fd_q <= feature_done;
  end

  // reads in flight now, and after this edge (stage RD_LAT leaves, issue enters)
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  always_comb begin
    inflight_nxt = CW'(issue);
    for (int i = 1; i < RD_LAT; i++) inflight_nxt = inflight_nxt + CW'(vld_pipe[i]);
  end

  // Reserve FIFO space for every read in flight so a push never finds it full.
  assign last_rd = (bank == 2'd3) && (addr == ADDR_LAST);
  assign issue   = (state == READ) && !abort && ((cnt + inflight) < DEPTH);
  assign res_enb   = issue ? (4'b0001 << bank) : 4'b0000;
  assign res_addrb = addr;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      bank <= '0;
    end else if (abort || start) begin
      addr <= '0;
      bank <= '0;
    end else if (issue) begin
      if (addr == ADDR_LAST) begin
        addr <= '0;
        bank <= bank + 2'd1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= '0;
    end else if (abort) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      tag_pipe[1] <= '{bank: bank, last: last_rd};
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // pipeline tail: pick the bank that was read RD_LAT cycles ago
  assign doutb = {res_doutb_3, res_doutb_2, res_doutb_1, res_doutb_0};
  assign push  = vld_pipe[RD_LAT];
  assign tail_beat = '{word: doutb[tag_pipe[RD_LAT].bank],
                       bank: tag_pipe[RD_LAT].bank,
                       last: tag_pipe[RD_LAT].last};

  // FWFT FIFO
  assign head     = mem[rd_ptr];
  assign m_tvalid = (cnt != '0);
  assign pop      = m_tvalid && m_tready;
  assign cnt_nxt  = cnt + CW'(push) - CW'(pop);
  assign m_tdata  = m_tvalid ? {{(16-QN){1'b0}}, head.word} : 16'd0;
  assign m_tuser  = m_tvalid ? head.bank : 2'd0;
  assign m_tlast  = m_tvalid && head.last;

  always_ff @(posedge aclk) begin
    if (push && !abort) mem[wr_ptr] <= tail_beat;
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt_nxt;
    end
  end

  // FSM
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DRAIN looks one edge ahead so done lands right after the tlast handshake.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    unique case (state)
      IDLE:  if (start) state_nxt = READ;
      READ:  if (issue && last_rd) state_nxt = DRAIN;
      DRAIN: if (cnt_nxt == '0 && inflight_nxt == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst)                          overrun <= 1'b0;
    else if (abort || start)          overrun <= 1'b0;
    else if (launch && state != IDLE) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_hog_feature_reader.sv
// Bench for hog_feature_reader: behavioural BRAMs, stream monitor, scenario table
// plus hand-written latency / stall / reset sequences. A second instance with
// FEAT_LEN=1, RD_LAT=3 covers the single-word-per-bank boundary.
module tb_hog_feature_reader;
  localparam int AW = 17;
  localparam int QN = 10;
  localparam int FL = 4;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  user;
    logic        last;
  } beat_t;

  typedef struct {
    string nm;
    bit    rnd_rdy;
    bit    rnd_data;
    int    abort_at;
    bit    relaunch;
    int    exp_done;
    bit    exp_ovr;
  } scen_t;

  logic aclk = 1'b0;
  logic rst = 1'b1;
  logic feature_done = 1'b0;
  logic abort = 1'b0;
  logic m_tready = 1'b1;
  bit   rdy_rand = 1'b0;
  bit   rdy_fixed = 1'b1;

  // DUT0 (FEAT_LEN=4, RD_LAT=1)
  logic [3:0]    res_enb;
  logic [AW-1:0] res_addrb;
  logic [QN-1:0] q0 [4];
  logic          m_tvalid, m_tlast, busy, done, overrun;
  logic [15:0]   m_tdata;
  logic [1:0]    m_tuser;

  // DUT1 (FEAT_LEN=1, RD_LAT=3)
  logic [3:0]    res_enb1;
  logic [AW-1:0] res_addrb1;
  logic [QN-1:0] p1 [4][3];
  logic          m_tvalid1, m_tlast1, busy1, done1, overrun1;
  logic [15:0]   m_tdata1;
  logic [1:0]    m_tuser1;

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  hog_feature_reader #(.RAM_AW(AW), .QN(QN), .FEAT_LEN(FL), .RD_LAT(1), .FIFO_DEPTH(4)) u_dut (
    .aclk(aclk), .rst(rst), .feature_done(feature_done), .abort(abort),
    .res_enb(res_enb), .res_addrb(res_addrb),
    .res_doutb_0(q0[0]), .res_doutb_1(q0[1]), .res_doutb_2(q0[2]), .res_doutb_3(q0[3]),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .busy(busy), .done(done), .overrun(overrun)
  );

  hog_feature_reader #(.RAM_AW(AW), .QN(QN), .FEAT_LEN(1), .RD_LAT(3), .FIFO_DEPTH(5)) u_dut1 (
    .aclk(aclk), .rst(rst), .feature_done(feature_done), .abort(abort),
    .res_enb(res_enb1), .res_addrb(res_addrb1),
    .res_doutb_0(p1[0][2]), .res_doutb_1(p1[1][2]), .res_doutb_2(p1[2][2]), .res_doutb_3(p1[3][2]),
    .m_tvalid(m_tvalid1), .m_tready(m_tready), .m_tdata(m_tdata1), .m_tuser(m_tuser1),
    .m_tlast(m_tlast1), .busy(busy1), .done(done1), .overrun(overrun1)
  );

  // behavioural BRAMs
  logic [QN-1:0] bram [4][FL];

  always @(posedge aclk) begin
    for (int k = 0; k < 4; k++)
      if (res_enb[k] && res_addrb < AW'(FL)) q0[k] <= bram[k][int'(res_addrb)];
  end

  always @(posedge aclk) begin
    for (int k = 0; k < 4; k++) begin
      if (res_enb1[k]) p1[k][0] <= QN'(100 + k);
      p1[k][1] <= p1[k][0];
      p1[k][2] <= p1[k][1];
    end
  end

  // stream monitor (records events and protocol violations; main block judges them)
  beat_t got[$];
  beat_t got1[$];
  int    done_cnt = 0, done1_cnt = 0, issued = 0, outst = 0, max_outst = 0;
  int    stall_viol = 0, done_order_viol = 0, busy_done_viol = 0, onehot_viol = 0, addr1_viol = 0;
  bit    prev_stall = 0, prev_last = 0, prev_done = 0;
  beat_t prev_beat;

  always @(negedge aclk) begin
    if (rst) begin
      prev_stall = 0;
      prev_last  = 0;
      prev_done  = 0;
      outst      = 0;
    end else begin
      if (prev_stall && ({m_tvalid, m_tdata, m_tuser, m_tlast} != {1'b1, prev_beat})) stall_viol++;
      if (done) begin
        done_cnt++;
        if (!prev_last) done_order_viol++;
      end
      if (prev_done && busy) busy_done_viol++;
      if (res_enb != 4'd0) begin
        issued++;
        outst++;
        if (!$onehot(res_enb)) onehot_viol++;
      end
      if (m_tvalid && m_tready) begin
        got.push_back('{data: m_tdata, user: m_tuser, last: m_tlast});
        outst--;
      end
      if (abort) outst = 0;
      if (outst > max_outst) max_outst = outst;
      prev_stall = m_tvalid && !m_tready && !abort;
      prev_beat  = '{data: m_tdata, user: m_tuser, last: m_tlast};
      prev_last  = m_tvalid && m_tready && m_tlast;
      prev_done  = done;
    end
  end

  always @(negedge aclk) begin
    if (!rst) begin
      if (m_tvalid1 && m_tready) got1.push_back('{data: m_tdata1, user: m_tuser1, last: m_tlast1});
      if (done1) done1_cnt++;
      if (res_enb1 != 4'd0 && res_addrb1 != '0) addr1_viol++;
    end
  end

  // checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, bit ok, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    check(nm, act === exp, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic launch();
    feature_done = 1'b1;
    tick();
    feature_done = 1'b0;
    tick();
  endtask

  task automatic fill(bit rnd);
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < FL; a++)
        bram[k][a] = rnd ? QN'($urandom) : QN'(k * 16 + a);
  endtask

  // reference: bank-major walk of the BRAM contents
  beat_t exp_q[$];
  function automatic void build_exp();
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < FL; a++)
        exp_q.push_back('{data: 16'(bram[k][a]), user: 2'(k), last: (k == 3 && a == FL - 1)});
  endfunction

  task automatic cmp_stream(string tag, int base, bit full);
    int n;
    n = got.size() - base;
    if (full) chk({tag, "_count"}, n, 4 * FL);
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), got[base + i], exp_q[i]);
  endtask

  task automatic wait_beats(string tag, int base, int n);
    int c;
    c = 0;
    while (got.size() - base < n && c < 2000) begin
      tick();
      c++;
    end
    check({tag, "_beats_timeout"}, got.size() - base >= n, got.size() - base, n);
  endtask

  task automatic wait_done(string tag, int bd);
    int c;
    c = 0;
    while (done_cnt == bd && c < 3000) begin
      tick();
      c++;
    end
    check({tag, "_done_timeout"}, done_cnt > bd, done_cnt - bd, 1);
  endtask

  scen_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, bd, bi, b1, bd1, n;

    tbl[0] = '{"t1",  0, 0, 0, 0, 1, 0};
    tbl[1] = '{"t2",  1, 0, 0, 0, 1, 0};
    tbl[2] = '{"t2r", 1, 1, 0, 0, 1, 0};
    tbl[3] = '{"t5",  0, 0, 0, 1, 1, 1};
    tbl[4] = '{"t4",  0, 1, 6, 0, 0, 0};
    tbl[5] = '{"t5r", 1, 1, 0, 1, 1, 1};
    tbl[6] = '{"t4b", 1, 0, 0, 0, 1, 0};

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_enb", res_enb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tdata", m_tdata, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // latency and no-bubble throughput; feature_done held high the whole time
    fill(0);
    build_exp();
    base = got.size(); bd = done_cnt; b1 = got1.size(); bd1 = done1_cnt;
    feature_done = 1'b1;
    @(negedge aclk);
    chk("pre_launch_busy", busy, 0);
    @(negedge aclk);
    chk("c1_enb", res_enb, 4'b0001);
    chk("c1_addr", res_addrb, 0);
    chk("c1_busy", busy, 1);
    @(negedge aclk);
    chk("c2_tvalid", m_tvalid, 0);
    for (int i = 0; i < 4 * FL; i++) begin
      @(negedge aclk);
      chk($sformatf("lat_beat%0d", i), {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, exp_q[i]});
    end
    @(negedge aclk);
    chk("lat_done", done, 1);
    chk("lat_tvalid_end", m_tvalid, 0);
    @(negedge aclk);
    chk("lat_busy_drop", busy, 0);
    chk("lat_done_once", done, 0);
    feature_done = 1'b0;
    repeat (2) tick();
    chk("lat_done_count", done_cnt - bd, 1);
    chk("held_high_overrun", overrun, 0);
    chk("held_high_beats", got.size() - base, 4 * FL);
    // FEAT_LEN=1 instance: one word per bank, tlast on bank3
    chk("fl1_count", got1.size() - b1, 4);
    for (int k = 0; k < 4 && b1 + k < got1.size(); k++)
      chk($sformatf("fl1_beat%0d", k), got1[b1 + k], {16'(100 + k), 2'(k), (k == 3)});
    chk("fl1_done_count", done1_cnt - bd1, 1);
    chk("fl1_busy", busy1, 0);
    chk("fl1_overrun", overrun1, 0);

    // scenario table
    foreach (tbl[s]) begin
      fill(tbl[s].rnd_data);
      build_exp();
      rdy_rand = tbl[s].rnd_rdy;
      rdy_fixed = 1'b1;
      base = got.size(); bd = done_cnt;
      launch();
      chk({tbl[s].nm, "_ovr_after_launch"}, overrun, 0);
      if (tbl[s].relaunch) begin
        wait_beats(tbl[s].nm, base, 5);
        feature_done = 1'b1;
        tick();
        feature_done = 1'b0;
        tick();
      end
      if (tbl[s].abort_at > 0) begin
        wait_beats(tbl[s].nm, base, tbl[s].abort_at);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge aclk);
        chk({tbl[s].nm, "_abort_tvalid"}, m_tvalid, 0);
        chk({tbl[s].nm, "_abort_busy"}, busy, 0);
        repeat (20) tick();
        n = got.size() - base;
        check({tbl[s].nm, "_abort_beats"}, n == tbl[s].abort_at || n == tbl[s].abort_at + 1,
              n, tbl[s].abort_at + 1);
        cmp_stream(tbl[s].nm, base, 1'b0);
      end else begin
        wait_done(tbl[s].nm, bd);
        repeat (2) tick();
        cmp_stream(tbl[s].nm, base, 1'b1);
      end
      chk({tbl[s].nm, "_done_count"}, done_cnt - bd, tbl[s].exp_done);
      chk({tbl[s].nm, "_overrun"}, overrun, tbl[s].exp_ovr);
      chk({tbl[s].nm, "_idle"}, busy, 0);
      rdy_rand = 1'b0;
      repeat (3) tick();
    end

    // T3: long stall right after launch
    fill(1);
    build_exp();
    rdy_fixed = 1'b0;
    repeat (2) tick();
    base = got.size(); bd = done_cnt; bi = issued;
    launch();
    repeat (40) tick();
    chk("t3_reads_stalled", issued - bi, 4);
    chk("t3_tvalid_held", m_tvalid, 1);
    chk("t3_no_beats", got.size() - base, 0);
    rdy_fixed = 1'b1;
    wait_done("t3", bd);
    repeat (2) tick();
    cmp_stream("t3", base, 1'b1);

    // T6: reset mid-readout, then a clean readout
    fill(1);
    build_exp();
    base = got.size();
    launch();
    wait_beats("t6", base, 5);
    rst = 1'b1;
    @(negedge aclk);
    chk("t6_rst_tvalid", m_tvalid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_enb", res_enb, 0);
    chk("t6_rst_done", done, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    base = got.size(); bd = done_cnt;
    launch();
    wait_done("t6", bd);
    repeat (2) tick();
    cmp_stream("t6", base, 1'b1);
    chk("t6_done_count", done_cnt - bd, 1);

    // protocol invariants gathered over the whole run
    chk("stall_data_stable", stall_viol, 0);
    chk("done_after_tlast", done_order_viol, 0);
    chk("busy_drop_after_done", busy_done_viol, 0);
    chk("enb_onehot", onehot_viol, 0);
    check("outstanding_le_depth", max_outst <= 4, max_outst, 4);
    chk("fl1_addr_zero", addr1_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
